life_step_engine: RTL
=====================

// Module: life_step_engine
// PURPOSE
//   Hardware Game-of-Life stepper that sits directly upstream of the double-buffered life
//   world store on its cell bus (cell_write/cell_address/cell_data_in/cell_data_out).
//   It reads the displayed generation, computes the next generation row by row (toroidal
//   64x48 grid, 2 x 32-bit words per row, word address {row[5:0], half}), and writes it
//   into the hidden buffer. It then flips the buffer index by writing address 7'h7F.
//   A step is triggered manually (start) or once per video frame (run + frame_tick).
// PARAMETERS
//   ROWS       48      grid rows; row r occupies word addresses {r,1'b0} (cols 0-31), {r,1'b1} (cols 32-63)
//   FLIP_ADDR  7'h7F   cell-bus address whose write sets the store's world index to data[0]
//   GEN_WIDTH  16      width of generation counter
// PORTS
//   clock          in   1          sole clock, rising edge
//   reset          in   1          synchronous, active-high
//   start          in   1          request one generation step (sampled only in IDLE)
//   run            in   1          auto-step enable
//   frame_tick     in   1          one-cycle pulse per video frame; starts a step when run=1 and IDLE
//   busy           out  1          high from the accepting edge until step_done
//   step_done      out  1          one-cycle pulse after the flip write
//   generation     out  GEN_WIDTH  completed steps since reset, wraps modulo 2^GEN_WIDTH
//   cell_write     out  1          write strobe to world store
//   cell_address   out  7          word address (reads and writes)
//   cell_data_in   out  32         write data to world store
//   cell_data_out  in   32         combinational read data for cell_address (same cycle)
// BEHAVIOUR
//   Reset values: busy=0, step_done=0, generation=0, cell_write=0, cell_address=0,
//     cell_data_in=0, internal index=0, state=INIT.
//   INIT (1 cycle after reset release): write FLIP_ADDR with data 0, forcing the store to
//     index 0 and resyncing with the internal index. busy=1. Go to IDLE.
//   IDLE: if start | (run & frame_tick), latch the request and go to PRE, with busy=1.
//     Simultaneous start and tick count as one step. start is ignored while busy.
//   PRE (6 cycles): read rows 47,0,1 (lo then hi word each) into window regs prev/cur/next.
//     Capture cell_data_out at the edge ending the cycle that drives cell_address.
//   Per row y = 0..47:
//     WR_LO: write {y,0} with next-state cols 0-31.
//     WR_HI: write {y,1} with next-state cols 32-63.
//     Shift window: prev<=cur, cur<=next.
//     If y<47: RD_LO, RD_HI fetch row (y+2) mod 48 into next.
//     If y=47: go to FLIP.
//   Cell x of a row = word[x/32] bit[x%32]. Neighbours wrap: col -1 -> 63, col 64 -> 0,
//     row -1 -> 47, row 48 -> 0.
//   Rule: count n of 8 neighbours (4-bit).
//     next = (n==3) | (alive & n==2).
//     All 64 cells of a row are computed combinationally from the window.
//   FLIP: write FLIP_ADDR with {31'b0, ~index}; index <= ~index; generation += 1.
//   DONE: step_done=1 for one cycle, busy=0, go to IDLE.
//   Latency: accept edge -> step_done high = 6 + 47*4 + 2 + 1 = 197 busy cycles, then
//     step_done.
//   cell_write is high only in INIT, WR_LO, WR_HI, FLIP. Writes never target the
//     displayed buffer (the store routes them to the hidden one).
//   Reset mid-step: abandon at once, no further writes, re-enter INIT. The store shows
//     buffer 0; a partial hidden buffer is discarded.
// TESTING
//   1. Glider in rows 0-2 (row0 bit1, row1 bit2, row2 bits0-2), start pulse ->
//      197 busy cycles. Buffer 1 holds row1 b0,b2; row2 b1,b2; row3 b1. FLIP data=1.
//      generation=1.
//   2. Blinker at row 47, cols 62,63,0 (wrap both halves) -> next gen cols 63 at rows
//      46,47,0. Checks horizontal and vertical toroidal wrap.
//   3. run=1, frame_tick every 300 cycles for 4 ticks -> 4 steps, flips write 1,0,1,0.
//      generation=4. Block pattern unchanged.
//   4. start and frame_tick together with run=1, then start again mid-step -> exactly
//      one step. Extra start ignored.
//   5. Assert reset at cycle 100 of a step -> next cycle cell_write=0. INIT writes 7'h7F
//      data 0. generation=0. busy drops, then a fresh step completes normally.
//   6. All-ones world -> every cell n=8, next world all zeros.
//      Empty world -> stays empty.

Source files
------------

// File: rtl/life_step_engine.sv
// rtl/life_step_engine.sv - Toroidal 64x48 Game-of-Life generation stepper on the world-store cell bus
module life_step_engine #(
    parameter int              ROWS      = 48,
    parameter logic [6:0]      FLIP_ADDR = 7'h7F,
    parameter int              GEN_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 run,
    input  logic                 frame_tick,
    output logic                 busy,
    output logic                 step_done,
    output logic [GEN_WIDTH-1:0] generation,
    output logic                 cell_write,
    output logic [6:0]           cell_address,
    output logic [31:0]          cell_data_in,
    input  logic [31:0]          cell_data_out
);

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_PRE, S_WR_LO, S_WR_HI, S_RD_LO, S_RD_HI, S_FLIP, S_DONE
    } state_t;

    localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

    state_t      state, state_next;
    logic        init_hold;
    logic [2:0]  pre_cnt;
    logic [5:0]  row_y;
    logic [5:0]  pre_row;
    logic [5:0]  fetch_row;
    logic [63:0] win_prev, win_cur, win_next;
    logic [63:0] life_next;
    logic        index;
    logic        step_req;

    // Bit x of a 64-bit row is column x; column indices wrap modulo 64 via 6-bit arithmetic.
    function automatic logic [63:0] life_row(input logic [63:0] up, input logic [63:0] mid,
                                             input logic [63:0] dn);
        logic [63:0] res;
        logic [5:0]  xc, xl, xr;
        logic [3:0]  n;
        res = '0;
        for (int x = 0; x < 64; x++) begin
            xc = 6'(x);
            xl = xc - 6'd1;
            xr = xc + 6'd1;
            n  = 4'(up[xl]) + 4'(up[xc]) + 4'(up[xr]) + 4'(mid[xl]) + 4'(mid[xr])
               + 4'(dn[xl]) + 4'(dn[xc]) + 4'(dn[xr]);
            res[x] = (n == 4'd3) | (mid[x] & (n == 4'd2));
        end
        return res;
    endfunction

    assign life_next = life_row(win_prev, win_cur, win_next);
    assign step_req  = start | (run & frame_tick);

    always_comb begin
        pre_row   = 6'd1;
        fetch_row = (row_y == LAST_ROW) ? 6'd0 : row_y + 6'd1;
        case (pre_cnt[2:1])
            2'd0:    pre_row = LAST_ROW;
            2'd1:    pre_row = 6'd0;
            default: pre_row = 6'd1;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_INIT:  if (!init_hold) state_next = S_IDLE;
            S_IDLE:  if (step_req) state_next = S_PRE;
            S_PRE:   if (pre_cnt == 3'd5) state_next = S_WR_LO;
            S_WR_LO: state_next = S_WR_HI;
            S_WR_HI: state_next = (row_y == LAST_ROW) ? S_FLIP : S_RD_LO;
            S_RD_LO: state_next = S_RD_HI;
            S_RD_HI: state_next = S_WR_LO;
            S_FLIP:  state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_INIT;
        endcase
    end

    // The cycle right after a reset edge keeps the bus quiet; the resync write follows it.
    always_comb begin
        busy         = 1'b0;
        step_done    = 1'b0;
        cell_write   = 1'b0;
        cell_address = 7'd0;
        cell_data_in = 32'd0;
        case (state)
            S_INIT: begin
                if (!init_hold) begin
                    busy         = 1'b1;
                    cell_write   = 1'b1;
                    cell_address = FLIP_ADDR;
                end
            end
            S_PRE: begin
                busy         = 1'b1;
                cell_address = {pre_row, pre_cnt[0]};
            end
            S_WR_LO: begin
                busy         = 1'b1;
                cell_write   = 1'b1;
                cell_address = {row_y, 1'b0};
                cell_data_in = life_next[31:0];
            end
            S_WR_HI: begin
                busy         = 1'b1;
                cell_write   = 1'b1;
                cell_address = {row_y, 1'b1};
                cell_data_in = life_next[63:32];
            end
            S_RD_LO: begin
                busy         = 1'b1;
                cell_address = {fetch_row, 1'b0};
            end
            S_RD_HI: begin
                busy         = 1'b1;
                cell_address = {fetch_row, 1'b1};
            end
            S_FLIP: begin
                busy         = 1'b1;
                cell_write   = 1'b1;
                cell_address = FLIP_ADDR;
                cell_data_in = {31'b0, ~index};
            end
            S_DONE:  step_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_INIT;
            init_hold  <= 1'b1;
            pre_cnt    <= 3'd0;
            row_y      <= 6'd0;
            win_prev   <= '0;
            win_cur    <= '0;
            win_next   <= '0;
            index      <= 1'b0;
            generation <= '0;
        end else begin
            state     <= state_next;
            init_hold <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (step_req) begin
                        pre_cnt <= 3'd0;
                        row_y   <= 6'd0;
                    end
                end
                S_PRE: begin
                    pre_cnt <= pre_cnt + 3'd1;
                    case (pre_cnt)
                        3'd0:    win_prev[31:0]  <= cell_data_out;
                        3'd1:    win_prev[63:32] <= cell_data_out;
                        3'd2:    win_cur[31:0]   <= cell_data_out;
                        3'd3:    win_cur[63:32]  <= cell_data_out;
                        3'd4:    win_next[31:0]  <= cell_data_out;
                        3'd5:    win_next[63:32] <= cell_data_out;
                        default: ;
                    endcase
                end
                S_WR_HI: begin
                    if (row_y != LAST_ROW) begin
                        win_prev <= win_cur;
                        win_cur  <= win_next;
                        row_y    <= row_y + 6'd1;
                    end
                end
                S_RD_LO: win_next[31:0]  <= cell_data_out;
                S_RD_HI: win_next[63:32] <= cell_data_out;
                S_FLIP: begin
                    index      <= ~index;
                    generation <= generation + {{(GEN_WIDTH-1){1'b0}}, 1'b1};
                end
                default: ;
            endcase
        end
    end

endmodule
